// File: rtl/sel_monitor.sv
// sel_monitor: receive-side checker for the active-low walking-LED select bus.
// Define SEL_MON_SYNC_EN to put a 2-flop synchronizer ahead of the sample register.
module sel_monitor #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        sel_i,
  input  logic              clr_i,
  output logic [3:0]        pos_o,
  output logic              dir_o,
  output logic              moved_o,
  output logic              illegal_o,
  output logic              err_o,
  output logic [STEP_W-1:0] step_cnt_o
);
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
  state_t            state_q;
  logic [7:0]        sel_in, sel_q, prev_q, inv;
  logic [3:0]        pos_q, cur, fwd_tgt, rev_tgt;
  logic              dir_q, moved_q, illegal_q, err_q;
  logic              valid, fwd, rev, legal, fresh, bad;
  logic [STEP_W-1:0] cnt_q;
`ifdef SEL_MON_SYNC_EN
  logic [7:0] s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 8'hFF;
      s2_q <= 8'hFF;
    end else begin
      s1_q <= sel_i;
      s2_q <= s1_q;
    end
  end
  assign sel_in = s2_q;
`else
  assign sel_in = sel_i;
`endif
  // prev_q lets a held sample be judged only once, so pulses never repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 8'hFF;
      prev_q <= 8'hFF;
    end else begin
      sel_q  <= sel_in;
      prev_q <= sel_q;
    end
  end
  assign inv = ~sel_q;
  always_comb begin
    cur = 4'd0;
    for (int b = 0; b < 8; b++)
      if (inv[b]) cur = 4'(8 - b);
  end
  assign valid   = (inv & (inv - 8'd1)) == 8'd0;
  assign fwd_tgt = (pos_q == 4'd0 || pos_q == 4'd8) ? 4'd1 : pos_q + 4'd1;
  assign rev_tgt = (pos_q <= 4'd1) ? 4'd8 : pos_q - 4'd1;
  assign fwd     = valid && cur == fwd_tgt;
  assign rev     = valid && cur == rev_tgt;
  assign legal   = valid && (cur == pos_q || cur == 4'd0 || fwd || rev);
  assign fresh   = sel_q != prev_q;
  assign bad     = fresh && !legal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pos_q     <= 4'd0;
      dir_q     <= 1'b1;
      moved_q   <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      moved_q   <= 1'b0;
      illegal_q <= 1'b0;
      if (bad) begin
        illegal_q <= 1'b1;
        err_q     <= 1'b1;
        state_q   <= FAULT;
      end else if (state_q == FAULT) begin
        if (legal) begin
          pos_q <= cur;
          dir_q <= fwd ? 1'b1 : rev ? 1'b0 : dir_q;
        end
        if (clr_i && valid) begin
          err_q   <= 1'b0;
          pos_q   <= cur;
          state_q <= (cur == 4'd0) ? IDLE : TRACK;
        end
      end else if (fwd || rev) begin
        pos_q   <= cur;
        dir_q   <= fwd;
        moved_q <= 1'b1;
        cnt_q   <= fwd ? cnt_q + STEP_W'(1) : cnt_q - STEP_W'(1);
        state_q <= TRACK;
      end else if (cur == 4'd0) begin
        pos_q   <= 4'd0;
        state_q <= IDLE;
      end
    end
  end
  assign pos_o      = pos_q;
  assign dir_o      = dir_q;
  assign moved_o    = moved_q;
  assign illegal_o  = illegal_q;
  assign err_o      = err_q;
  assign step_cnt_o = cnt_q;
endmodule

// File: tb/tb_sel_monitor.sv
// tb_sel_monitor: directed bench for sel_monitor (default build, 2-edge latency)
// with a per-cycle reference model and literal checkpoints.
module tb_sel_monitor;
  logic       clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic [7:0] sel = 8'hFF;
  logic [3:0] pos;
  logic       dir, moved, illegal, err;
  logic [7:0] cnt;
  int checks = 0, failures = 0, n_moved = 0, n_illegal = 0;

  always #5 clk = ~clk;

  sel_monitor #(.STEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel_i(sel), .clr_i(clr),
    .pos_o(pos), .dir_o(dir), .moved_o(moved), .illegal_o(illegal),
    .err_o(err), .step_cnt_o(cnt)
  );

  typedef struct {
    int       pos;
    bit       dir, moved, illegal, err, fault;
    bit [7:0] cnt, smp, prev;
  } m_t;
  m_t m;

  function automatic m_t rst_state();
    m_t r;
    r.pos = 0; r.dir = 1; r.moved = 0; r.illegal = 0; r.err = 0; r.fault = 0;
    r.cnt = 0; r.smp = 8'hFF; r.prev = 8'hFF;
    return r;
  endfunction

  // rules applied to the sample taken one edge earlier; positions live on a ring 1..8
  function automatic m_t nxt(m_t s, bit [7:0] si, bit c);
    m_t t = s;
    bit [7:0] z = ~s.smp;
    int cur = 0, p = s.pos;
    bit ok_shape = $countones(z) <= 1;
    bit fw, rv, ok, newer;
    for (int b = 0; b < 8; b++) if (z[b]) cur = 8 - b;
    fw = ok_shape && cur != 0 && cur == ((p == 0 ? 8 : p) % 8) + 1;
    rv = ok_shape && cur != 0 && cur == (((p == 0 ? 1 : p) + 6) % 8) + 1;
    ok = ok_shape && (cur == p || cur == 0 || fw || rv);
    newer = s.smp != s.prev;
    t.moved = 0; t.illegal = 0; t.prev = s.smp; t.smp = si;
    if (newer && !ok) begin
      t.illegal = 1; t.err = 1; t.fault = 1;
    end else if (s.fault) begin
      if (ok) begin
        t.pos = cur;
        if (fw) t.dir = 1;
        if (rv) t.dir = 0;
      end
      if (c && ok_shape) begin
        t.err = 0; t.fault = 0; t.pos = cur;
      end
    end else if (fw || rv) begin
      t.pos = cur; t.dir = fw; t.moved = 1;
      t.cnt = fw ? s.cnt + 8'd1 : s.cnt - 8'd1;
    end else if (cur == 0) begin
      t.pos = 0;
    end
    return t;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= rst_state();
    else m <= nxt(m, sel, clr);

  always @(posedge clk) begin
    #1;
    checks++;
    if ({pos, dir, moved, illegal, err, cnt} !==
        {4'(m.pos), m.dir, m.moved, m.illegal, m.err, m.cnt}) begin
      failures++;
      $display("FAIL model t=%0t pos=%0d/%0d dir=%0b/%0b moved=%0b/%0b illegal=%0b/%0b err=%0b/%0b cnt=%0h/%0h (dut/model)",
               $time, pos, m.pos, dir, m.dir, moved, m.moved, illegal, m.illegal, err, m.err, cnt, m.cnt);
    end
    if (moved) n_moved++;
    if (illegal) n_illegal++;
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(bit [7:0] v, int n);
    sel = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; n_moved = 0; n_illegal = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pos", pos, 0); chk("rst_dir", dir, 1); chk("rst_cnt", cnt, 0);
    chk("rst_err", err, 0); chk("rst_moved", moved, 0); chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    drive(8'hFF, 3);
    drive(8'h7F, 3); chk("fw_pos1", pos, 1);
    drive(8'hBF, 3); chk("fw_pos2", pos, 2);
    drive(8'hDF, 3); chk("fw_pos3", pos, 3);
    chk("fw_dir", dir, 1); chk("fw_cnt", cnt, 3);
    chk("fw_moved_pulses", n_moved, 3); chk("fw_no_illegal", n_illegal, 0);

    do_reset();
    drive(8'hFE, 3); chk("rv_pos8", pos, 8); chk("rv_dir", dir, 0); chk("rv_cnt_ff", cnt, 8'hFF);
    drive(8'hFD, 3); chk("rv_pos7", pos, 7); chk("rv_cnt_fe", cnt, 8'hFE);

    do_reset();
    drive(8'h7F, 3); chk("wrap_cnt_start", cnt, 1);
    drive(8'hFE, 3); chk("wrap_1to8_pos", pos, 8); chk("wrap_1to8_dir", dir, 0); chk("wrap_1to8_cnt", cnt, 0);
    drive(8'h7F, 3); chk("wrap_8to1_pos", pos, 1); chk("wrap_8to1_dir", dir, 1);
    chk("wrap_cnt_back", cnt, 1); chk("wrap_moved", n_moved, 3);

    drive(8'hDF, 3);
    chk("jump_illegal", n_illegal, 1); chk("jump_err", err, 1);
    chk("jump_pos_held", pos, 1); chk("jump_cnt_frozen", cnt, 1);
    drive(8'h3F, 3); chk("multihot_illegal", n_illegal, 2);

    clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("clr_invalid_err", err, 1); chk("clr_invalid_no_pulse", n_illegal, 2);
    drive(8'hFF, 3);
    clr = 1'b0;
    chk("clr_valid_err", err, 0); chk("clr_valid_pos", pos, 0);
    drive(8'hDF, 3); chk("refault_err", err, 1); chk("refault_illegal", n_illegal, 3);
    sel = 8'hEF;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_illegal_err", err, 1); chk("clr_vs_illegal_pulse", n_illegal, 4);

    do_reset();
    drive(8'h7F, 3); drive(8'hBF, 3); drive(8'hDF, 3); drive(8'hEF, 3); drive(8'hF7, 3);
    drive(8'hFD, 3);
    chk("pre_rst_pos", pos, 5); chk("pre_rst_cnt", cnt, 5); chk("pre_rst_err", err, 1);
    #2 rst_n = 1'b0; n_illegal = 0;
    #1;
    chk("async_pos", pos, 0); chk("async_dir", dir, 1); chk("async_cnt", cnt, 0);
    chk("async_err", err, 0); chk("async_moved", moved, 0); chk("async_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1; sel = 8'hBF;
    repeat (3) @(negedge clk);
    chk("post_rst_illegal", n_illegal, 1); chk("post_rst_err", err, 1); chk("post_rst_pos", pos, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
